// File: rtl/cache_repl_pkg.sv
// Shared types and constants for the cache replacement controller.
// Used by cache_repl_ctrl and cache_repl_lfsr.
package cache_repl_pkg;

    typedef enum logic [1:0] {
        REPL_RR   = 2'd0,
        REPL_PLRU = 2'd1,
        REPL_RAND = 2'd2
    } repl_t;

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } ctrl_state_t;

    localparam logic [15:0] LFSR_SEED = 16'h0001;
    // Galois feedback for x^16 + x^14 + x^13 + x^11 + 1, right-shifting form
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic int state_width(input int ways);
        int lg;
        lg = $clog2(ways);
        return (ways - 1 > lg) ? ways - 1 : lg;
    endfunction

endpackage

// File: rtl/cache_repl_lfsr.sv
// 16-bit Galois LFSR feeding the random replacement policy.
// Only instantiated when CACHE_REPL_RANDOM_EN is defined.
module cache_repl_lfsr
    import cache_repl_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        step,
    output logic [15:0] value
);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            value <= LFSR_SEED;
        end else if (step) begin
            value <= {1'b0, value[15:1]} ^ (value[0] ? LFSR_TAPS : 16'h0000);
        end
    end

endmodule

// File: rtl/cache_repl_ctrl.sv
// Per-set victim selection (round-robin / tree-PLRU / random) with an init sweep.
// Define CACHE_REPL_RANDOM_EN to build the LFSR; otherwise REPL=2 falls back to round-robin.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_INIT  | sweeping set state to zero, one set per cycle; updates ignored
// ST_READY | lookups use stored state; hit/fill updates accepted
module cache_repl_ctrl
    import cache_repl_pkg::*;
#(
    parameter int NUMWAYS = 4,
    parameter int NUMSETS = 64,
    parameter int REPL    = 1
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       FlushReq,
    input  logic [$clog2(NUMSETS)-1:0] SetIdx,
    input  logic [NUMWAYS-1:0]         ValidWay,
    input  logic                       AccessEn,
    input  logic [NUMWAYS-1:0]         HitWay,
    input  logic                       FillEn,
    input  logic [NUMWAYS-1:0]         FillWay,
    output logic [NUMWAYS-1:0]         VictimWay,
    output logic                       Ready
);

    localparam int WAYW = $clog2(NUMWAYS);
    localparam int SETW = $clog2(NUMSETS);
    localparam int STW  = state_width(NUMWAYS);

`ifdef CACHE_REPL_RANDOM_EN
    localparam int POLICY = REPL;
`else
    localparam int POLICY = (REPL == int'(REPL_RAND)) ? int'(REPL_RR) : REPL;
`endif

    ctrl_state_t     state;
    logic [SETW-1:0] init_cnt;
    logic [STW-1:0]  set_state [NUMSETS];

    logic [STW-1:0]     cur_state;
    logic [STW-1:0]     next_state;
    logic [NUMWAYS-1:0] upd_way;
    logic [WAYW-1:0]    upd_idx;
    logic [WAYW-1:0]    pol_idx;
    logic [WAYW-1:0]    inv_idx;
    logic               any_inv;
    logic               upd_en;

    assign cur_state = set_state[SetIdx];
    assign upd_en    = Ready && (AccessEn || FillEn);
    assign upd_way   = FillEn ? FillWay : HitWay;

`ifdef CACHE_REPL_RANDOM_EN
    logic [15:0] lfsr_value;

    cache_repl_lfsr u_lfsr (
        .clk     (clk),
        .reset_n (reset_n),
        .step    (Ready && FillEn && !FlushReq),
        .value   (lfsr_value)
    );
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= ST_INIT;
            init_cnt <= '0;
            Ready    <= 1'b0;
        end else if (FlushReq) begin
            state    <= ST_INIT;
            init_cnt <= '0;
            Ready    <= 1'b0;
        end else if (state == ST_INIT) begin
            if (init_cnt == SETW'(NUMSETS - 1)) begin
                state <= ST_READY;
                Ready <= 1'b1;
            end
            init_cnt <= init_cnt + SETW'(1);
        end
    end

    // The state array needs no reset: every entry is rewritten by the sweep before Ready rises.
    always_ff @(posedge clk) begin
        if (reset_n && !FlushReq) begin
            if (state == ST_INIT) begin
                set_state[init_cnt] <= '0;
            end else if (upd_en) begin
                set_state[SetIdx] <= next_state;
            end
        end
    end

    always_comb begin
        upd_idx = '0;
        for (int w = 0; w < NUMWAYS; w++) begin
            if (upd_way[w]) upd_idx = upd_idx | WAYW'(w);
        end
    end

    // Tree levels split ways by index bit, LSB at the root; a node bit of 1 points at the odd half.
    always_comb begin
        int node;
        next_state = cur_state;
        node       = 0;
        if (POLICY == int'(REPL_PLRU)) begin
            for (int l = 0; l < WAYW; l++) begin
                for (int n = 0; n < STW; n++) begin
                    if (n == node) next_state[n] = ~upd_idx[l];
                end
                node = 2 * node + 1 + int'(upd_idx[l]);
            end
        end else if (POLICY == int'(REPL_RR)) begin
            if (FillEn) next_state[WAYW-1:0] = cur_state[WAYW-1:0] + WAYW'(1);
        end
    end

    always_comb begin
        int   node;
        logic b;
        pol_idx = '0;
        node    = 0;
        b       = 1'b0;
        if (POLICY == int'(REPL_PLRU)) begin
            for (int l = 0; l < WAYW; l++) begin
                b = 1'b0;
                for (int n = 0; n < STW; n++) begin
                    if (n == node) b = cur_state[n];
                end
                pol_idx[l] = b;
                node       = 2 * node + 1 + int'(b);
            end
`ifdef CACHE_REPL_RANDOM_EN
        end else if (POLICY == int'(REPL_RAND)) begin
            pol_idx = lfsr_value[WAYW-1:0];
`endif
        end else begin
            pol_idx = cur_state[WAYW-1:0];
        end
    end

    always_comb begin
        inv_idx = '0;
        any_inv = 1'b0;
        for (int w = NUMWAYS - 1; w >= 0; w--) begin
            if (!ValidWay[w]) begin
                inv_idx = WAYW'(w);
                any_inv = 1'b1;
            end
        end
    end

    always_comb begin
        if (!Ready)       VictimWay = NUMWAYS'(1);
        else if (any_inv) VictimWay = NUMWAYS'(1) << inv_idx;
        else              VictimWay = NUMWAYS'(1) << pol_idx;
    end

    always_ff @(posedge clk) begin
        if (reset_n && Ready && AccessEn) assert ($onehot(HitWay));
        if (reset_n && Ready && FillEn)   assert ($onehot(FillWay));
    end

endmodule
